regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter for the 32x32 `RegisterUnit`. It shares that unit's single write port (`RUWr`/`rd`/`DataWr`) between N write-back requesters, such as the ALU path and the load path, using round-robin arbitration and valid/ready handshakes. The drive to the register file is registered, and writes to x0 are filtered out. It sits between the execute/memory write-back sources and `RegisterUnit`.

## Interface
Parameters:
- `NUM_REQ`, 2, number of write-back requesters (2..8)
- `XLEN`, 32, data width
- `REG_AW`, 5, register address width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset is synchronous and active-high
- `req_valid`  in  NUM_REQ  requester i has a write pending
- `req_ready`  out  NUM_REQ  requester i granted this cycle (one-hot or zero)
- `req_rd`  in  NUM_REQ x REG_AW  destination register per requester
- `req_data`  in  NUM_REQ x XLEN  write data per requester
- `wb_stall`  in  1  freeze: no grants, no register-file write
- `RUWr`  out  1  register-file write enable (registered)
- `rd`  out  REG_AW  register-file write address (registered)
- `DataWr`  out  XLEN  register-file write data (registered)
- `grant_idx`  out  clog2(NUM_REQ)  index of last granted requester (registered)

## Operation
- State:
  - round-robin pointer `prio` (the requester with highest priority)
  - output registers `RUWr`, `rd`, `DataWr`, `grant_idx`
- Handshake: transfer for requester i when `req_valid[i] && req_ready[i]`. A requester holds `req_rd`/`req_data` stable while valid and not ready. Valid must not drop before the transfer.
- Arbitration (combinational):
  - If `wb_stall=0`, `req_ready` is one-hot on the first valid requester scanning `prio`, `prio+1`, ... mod `NUM_REQ`.
  - If no requester is valid, or `wb_stall=1`, `req_ready=0`.
- On a transfer from i:
  - next `rd=req_rd[i]`, `DataWr=req_data[i]`, `grant_idx=i`
  - next `RUWr=1` unless `req_rd[i]==0`. An x0 write completes the handshake but drives `RUWr=0`.
  - `prio` becomes `(i+1) mod NUM_REQ`.
- No transfer: next `RUWr=0`; `rd`/`DataWr`/`grant_idx` hold; `prio` holds.
- `wb_stall=1`: no transfer, so `RUWr=0` in the next cycle and `prio` is frozen. An already-registered write completes normally.
- Same `rd` from two requesters in the same cycle: only the winner transfers. The loser writes in a later cycle, so the later grant's value is final.

## Timing
- Reset values:
  - `RUWr=0`, `rd=0`, `DataWr=0`, `grant_idx=0`, `prio=0`
  - `req_ready=0` while `rst=1`
- Latency:
  - handshake in cycle t; `RUWr`/`rd`/`DataWr` valid during cycle t+1
  - register file updated at the rising edge ending t+1
- Throughput: one write per cycle. With all N valid and no stall, each requester is granted exactly once every N cycles.
- `rst` asserted mid-operation: an in-flight registered write is dropped (`RUWr=0` next cycle). Requesters must re-present their requests.
- Pointer wrap: the grant to `NUM_REQ-1` sets `prio=0`.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined adds the following ports:
  - `rs1`, `rs2` in REG_AW
  - `rf_rs1_data`, `rf_rs2_data` in XLEN, from `RURs1`/`RURs2`
  - `fwd_rs1_data`, `fwd_rs2_data` out XLEN
- Forwarding behaviour with the macro: `fwd_rsN_data = DataWr` when `RUWr && rd==rsN && rd!=0`; otherwise `rf_rsN_data`. This is combinational and covers the cycle in which the register file has not yet updated.
- Without the macro: these ports and the logic are absent. Consumers read `RURs1`/`RURs2` directly and must tolerate one cycle of stale data.

## Structure
- Package `regfile_pkg` holds:
  - `XLEN`, `REG_AW`, `REG_ZERO` (=0)
  - `wb_req_t` struct {`rd`, `data`}
- Sub-module `rr_arbiter`: parameterized `NUM_REQ` round-robin grant with `req`, `en`, `grant` (one-hot), `grant_idx`, and internal `prio` register.
- Top level: output registers, x0 filter, optional bypass.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `req_valid=2'b11` -> `req_ready=0`, `RUWr=0`, `rd=0`, `DataWr=0`.
- Single write: `req_valid[0]=1`, `rd=5`, `data=1234` -> `req_ready[0]=1` at t, then `RUWr=1`, `rd=5`, `DataWr=1234` at t+1, and `RUWr=0` at t+2.
- Contention: both valid for 4 cycles with (rd 3, 0xA) and (rd 4, 0xB) held -> grants alternate 0,1,0,1; writes follow one cycle later; `grant_idx` tracks the grants.
- x0 filter: requester 1 writes `rd=0`, `data=0xFFFF` -> `req_ready[1]=1`, `RUWr=0` next cycle, `prio` advances to 0.
- Stall: `wb_stall=1` for 3 cycles with requester 0 valid -> `req_ready=0` and `RUWr=0` throughout. Grant happens on the first cycle after release.
- Bypass (`REGFILE_WB_BYPASS_EN`): write `rd=7`, `data=0x55` with `rs1=7`, `rf_rs1_data=0` -> `fwd_rs1_data=0x55` in cycle t+1. With `rs1=0`, the output is `rf_rs1_data`.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin grant: one-hot grant on the first requester at or after prio,
// and prio moves just past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic [$clog2(NUM_REQ)-1:0] prio
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic found;
  int   scan_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = 0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = (int'(prio) + k) % NUM_REQ;
        if (!found && req[scan_idx]) begin
          found           = 1'b1;
          grant[scan_idx] = 1'b1;
          grant_idx       = IDX_W'(scan_idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= '0;
    end else if (found) begin
      prio <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Registered, round-robin shared write port for the 32x32 register file with x0 filtering.
// Optional read-after-write forwarding is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = regfile_pkg::XLEN,
  parameter int REG_AW  = regfile_pkg::REG_AW
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][REG_AW-1:0]    req_rd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]      req_data,
  input  logic                              wb_stall,
  output logic                              RUWr,
  output logic [REG_AW-1:0]                 rd,
  output logic [XLEN-1:0]                   DataWr,
  output logic [$clog2(NUM_REQ)-1:0]        grant_idx
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0]                 rs1,
  input  logic [REG_AW-1:0]                 rs2,
  input  logic [XLEN-1:0]                   rf_rs1_data,
  input  logic [XLEN-1:0]                   rf_rs2_data,
  output logic [XLEN-1:0]                   fwd_rs1_data,
  output logic [XLEN-1:0]                   fwd_rs2_data
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Handshake: requester i transfers in a cycle where req_valid[i] && req_ready[i];
  // it holds req_rd/req_data stable and keeps valid high until that cycle.
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   prio;
  logic               xfer;
  logic [REG_AW-1:0]  sel_rd;
  logic [XLEN-1:0]    sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (!wb_stall && !rst),
    .grant     (grant),
    .grant_idx (arb_idx),
    .prio      (prio)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign sel_rd    = req_rd[arb_idx];
  assign sel_data  = req_data[arb_idx];

  // An x0 write still consumes the grant; only the enable is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      RUWr      <= 1'b0;
      rd        <= '0;
      DataWr    <= '0;
      grant_idx <= '0;
    end else if (xfer) begin
      RUWr      <= (sel_rd != REG_AW'(REG_ZERO));
      rd        <= sel_rd;
      DataWr    <= sel_data;
      grant_idx <= arb_idx;
    end else begin
      RUWr      <= 1'b0;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Covers the cycle where the registered write has not reached the file yet.
  assign fwd_rs1_data = (RUWr && rd == rs1 && rd != REG_AW'(REG_ZERO)) ? DataWr : rf_rs1_data;
  assign fwd_rs2_data = (RUWr && rd == rs2 && rd != REG_AW'(REG_ZERO)) ? DataWr : rf_rs2_data;
`endif

endmodule
